// File: rtl/conv_kxk_pipe_pkg.sv
// Shared helpers for the KxK convolution pipe: log2, tree depth, latency and tap indexing.
package conv_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int tree_depth(input int k);
    return clog2(k * k);
  endfunction

  function automatic int lat(input int k);
    return tree_depth(k) + 2;
  endfunction

  function automatic int tap_idx(input int k, input int r, input int c);
    return k * r + c;
  endfunction

  // Operand count left after l pairwise-reduction levels of n inputs.
  function automatic int tree_cnt(input int n, input int l);
    return (n + (1 << l) - 1) >> l;
  endfunction

endpackage

// File: rtl/conv_kxk_pipe_adder_tree.sv
// Registered pairwise adder tree with a parallel valid shift register.
// CONV_KXK_RELU_EN: the final level clamps negative sums to zero.
module adder_tree_pipe
  import conv_pkg::*;
#(
  parameter int N = 25,
  parameter int W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              i_valid,
  input  logic [N-1:0][W-1:0] i_ops,
  output logic              o_valid,
  output logic [W-1:0]      o_sum
);
  localparam int DEPTH = clog2(N);

  logic [W-1:0]     w_src [DEPTH][N];
  logic [W-1:0]     w_nxt [DEPTH][N];
  logic [W-1:0]     r_lvl [DEPTH][N];
  logic [DEPTH-1:0] r_vld_pipe;

  for (genvar l = 0; l < DEPTH; l++) begin : g_lvl
    localparam int NI = tree_cnt(N, l);
    localparam int NO = tree_cnt(N, l + 1);
    for (genvar i = 0; i < N; i++) begin : g_node
      if (l == 0) begin : g_in
        assign w_src[l][i] = i_ops[i];
      end else begin : g_chain
        assign w_src[l][i] = r_lvl[l-1][i];
      end
      if (2*i + 1 < NI) begin : g_add
        logic [W-1:0] w_sum;
        assign w_sum = w_src[l][2*i] + w_src[l][2*i+1];
        if (l == DEPTH - 1) begin : g_fin
`ifdef CONV_KXK_RELU_EN
          assign w_nxt[l][i] = w_sum[W-1] ? '0 : w_sum;
`else
          assign w_nxt[l][i] = w_sum;
`endif
        end else begin : g_mid
          assign w_nxt[l][i] = w_sum;
        end
      end else if (i < NO) begin : g_pass
        // odd leftover rides one register to keep alignment with its peers
        assign w_nxt[l][i] = w_src[l][2*i];
      end else begin : g_zero
        assign w_nxt[l][i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vld_pipe <= '0;
      for (int l = 0; l < DEPTH; l++)
        for (int i = 0; i < N; i++) r_lvl[l][i] <= '0;
    end else if (en) begin
      r_vld_pipe <= {r_vld_pipe[DEPTH-2:0], i_valid};
      for (int l = 0; l < DEPTH; l++)
        for (int i = 0; i < N; i++) r_lvl[l][i] <= w_nxt[l][i];
    end
  end

  assign o_valid = r_vld_pipe[DEPTH-1];
  assign o_sum   = r_lvl[DEPTH-1][0];
endmodule

// File: rtl/conv_kxk_pipe.sv
// KxK sliding-window convolution: window shift, fill count, registered multiply, adder tree.
// CONV_KXK_RELU_EN (optional): clamp negative results to zero in the last tree stage.
module conv_kxk_pipe
  import conv_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int OUT_WIDTH = 32,
  parameter int K         = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       row_start,
  input  logic                       in_valid,
  input  logic [BIT_WIDTH*K-1:0]     column_in,
  input  logic                       filter_load,
  input  logic [BIT_WIDTH*K*K-1:0]   filter,
  output logic                       out_valid,
  output logic [OUT_WIDTH-1:0]       conv_value,
  output logic                       window_full
);
  localparam int N  = K * K;
  localparam int PW = 2 * BIT_WIDTH;
  localparam int CW = clog2(K + 1);

  if (OUT_WIDTH < PW + clog2(N)) begin : g_bad_width
    $error("conv_kxk_pipe: OUT_WIDTH too small for BIT_WIDTH/K");
  end
  if (K < 3 || K > 7) begin : g_bad_k
    $error("conv_kxk_pipe: K must be 3..7");
  end

  logic signed [BIT_WIDTH-1:0] r_win   [K][K];
  logic signed [BIT_WIDTH-1:0] r_wt    [N];
  logic signed [BIT_WIDTH-1:0] r_wt_s0 [N];
  logic signed [PW-1:0]        w_prod  [N];
  logic [N-1:0][OUT_WIDTH-1:0] r_prod;
  logic [CW-1:0]               r_cnt;
  logic                        r_v0, r_v1;
  logic                        w_accept, w_launch;

  assign w_accept = en & in_valid;
  assign w_launch = w_accept & ~row_start & (r_cnt >= CW'(K - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) r_win[r][c] <= '0;
    end else if (w_accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) r_win[r][c] <= r_win[r][c+1];
        r_win[r][K-1] <= column_in[BIT_WIDTH*r +: BIT_WIDTH];
      end
    end
  end

  // r_wt_s0 trails r_wt by one edge so a window launched on a load edge sees the old weights.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int j = 0; j < N; j++) begin
        r_wt[j]    <= '0;
        r_wt_s0[j] <= '0;
      end
    end else if (en) begin
      for (int j = 0; j < N; j++) begin
        r_wt_s0[j] <= r_wt[j];
        if (filter_load) r_wt[j] <= filter[BIT_WIDTH*j +: BIT_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
      r_v0  <= 1'b0;
    end else if (en) begin
      r_v0 <= w_launch;
      if (w_accept)
        r_cnt <= row_start ? CW'(1) : ((r_cnt == CW'(K)) ? CW'(K) : r_cnt + CW'(1));
      else if (row_start)
        r_cnt <= '0;
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      localparam int J = tap_idx(K, r, c);
      assign w_prod[J] = PW'(r_win[r][c]) * PW'(r_wt_s0[J]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prod <= '0;
      r_v1   <= 1'b0;
    end else if (en) begin
      r_v1 <= r_v0;
      for (int j = 0; j < N; j++) r_prod[j] <= OUT_WIDTH'(w_prod[j]);
    end
  end

  adder_tree_pipe #(.N(N), .W(OUT_WIDTH)) u_tree (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .i_valid (r_v1),
    .i_ops   (r_prod),
    .o_valid (out_valid),
    .o_sum   (conv_value)
  );

  assign window_full = (r_cnt == CW'(K));
endmodule

// File: tb/tb_conv_kxk_pipe.sv
// Scoreboard bench for conv_kxk_pipe (K=5): a behavioural window model queues expected sums.
module tb_conv_kxk_pipe;
  localparam int BW  = 8;
  localparam int OW  = 32;
  localparam int K   = 5;
  localparam int N   = K * K;
  localparam int LAT = 7;

  logic            clk = 1'b0;
  logic            rst, en, row_start, in_valid, filter_load;
  logic [BW*K-1:0] column_in;
  logic [BW*N-1:0] filter;
  logic            out_valid, window_full;
  logic [OW-1:0]   conv_value;

  int n_chk = 0, n_err = 0;
  int exp_q[$];
  int m_win [K][K];
  int m_wt  [N];
  int m_cnt;
  logic en_q, rst_q;

  conv_kxk_pipe #(.BIT_WIDTH(BW), .OUT_WIDTH(OW), .K(K)) dut (
    .clk(clk), .rst(rst), .en(en), .row_start(row_start), .in_valid(in_valid),
    .column_in(column_in), .filter_load(filter_load), .filter(filter),
    .out_valid(out_valid), .conv_value(conv_value), .window_full(window_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int relu(input int s);
`ifdef CONV_KXK_RELU_EN
    return (s < 0) ? 0 : s;
`else
    return s;
`endif
  endfunction

  function automatic logic [BW*K-1:0] col_all(input int v);
    logic [BW*K-1:0] c;
    for (int r = 0; r < K; r++) c[BW*r +: BW] = BW'(v);
    return c;
  endfunction

  function automatic logic [BW*K-1:0] col_rand();
    logic [BW*K-1:0] c;
    for (int r = 0; r < K; r++) c[BW*r +: BW] = BW'($urandom);
    return c;
  endfunction

  task automatic set_filter(input int v);
    for (int j = 0; j < N; j++) filter[BW*j +: BW] = BW'(v);
  endtask

  task automatic set_filter_rand();
    for (int j = 0; j < N; j++) filter[BW*j +: BW] = BW'($urandom);
  endtask

  // A result is new when out_valid is seen after an enabled, non-reset edge.
  always @(posedge clk) begin
    en_q  <= en;
    rst_q <= rst;
  end

  always @(negedge clk) begin
    if (rst_q === 1'b1 && en_q === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) check("unexp_out", 32'(out_valid), 0);
      else check("conv", longint'($signed(conv_value)), exp_q.pop_front());
    end
  end

  // Drive one cycle (called just after a falling edge) and advance the model alongside.
  task automatic beat(input logic e, input logic v, input logic rs, input logic fl,
                      input logic [BW*K-1:0] col);
    int sum;
    en = e; in_valid = v; row_start = rs; filter_load = fl; column_in = col;
    if (e && v) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) m_win[r][c] = m_win[r][c+1];
        m_win[r][K-1] = int'($signed(col[BW*r +: BW]));
      end
      if (!rs && m_cnt >= K - 1) begin
        sum = 0;
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++) sum += m_win[r][c] * m_wt[K*r + c];
        exp_q.push_back(relu(sum));
      end
      m_cnt = rs ? 1 : ((m_cnt == K) ? K : m_cnt + 1);
    end else if (e && rs) begin
      m_cnt = 0;
    end
    if (e && fl)
      for (int j = 0; j < N; j++) m_wt[j] = int'($signed(filter[BW*j +: BW]));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    beat(1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic load_filter();
    beat(1'b1, 1'b0, 1'b0, 1'b1, '0);
  endtask

  task automatic drain(input string tag);
    repeat (12) idle();
    check(tag, exp_q.size(), 0);
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_cnt = 0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) m_win[r][c] = 0;
    for (int j = 0; j < N; j++) m_wt[j] = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic rec_v;
    logic [OW-1:0] rec_c;
    rst = 1'b0; en = 1'b1; row_start = 1'b0; in_valid = 1'b0; filter_load = 1'b0;
    column_in = '0; filter = '0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_conv", conv_value, 0);
    check("rst_full", window_full, 0);
    rst = 1'b1;

    // all ones: 25 per window, latency check, then one result per beat
    set_filter(1); load_filter();
    beat(1, 1, 1, 0, col_all(1));
    repeat (3) beat(1, 1, 0, 0, col_all(1));
    check("full_after_4", window_full, 0);
    beat(1, 1, 0, 0, col_all(1));
    check("full_after_5", window_full, 1);
    lat = 1;
    while (!out_valid && lat < 20) begin
      idle();
      lat++;
    end
    check("latency", lat, LAT);
    repeat (3) beat(1, 1, 0, 0, col_all(1));
    drain("drain_ones");

    // column index pattern; first beat is row_start on a full window
    beat(1, 1, 1, 0, col_all(0));
    check("rs_on_full", window_full, 0);
    for (int c = 1; c <= 6; c++) beat(1, 1, 0, 0, col_all(c));
    drain("drain_ramp");

    // signed extremes
    set_filter(-128); load_filter();
    beat(1, 1, 1, 0, col_all(-128));
    repeat (4) beat(1, 1, 0, 0, col_all(-128));
    drain("drain_neg_neg");
    set_filter(127); load_filter();
    beat(1, 1, 1, 0, col_all(-128));
    repeat (4) beat(1, 1, 0, 0, col_all(-128));
    drain("drain_pos_neg");

    // stall for three cycles while a result is showing
    set_filter_rand(); load_filter();
    beat(1, 1, 1, 0, col_rand());
    lat = 0;
    while (!out_valid && lat < 20) begin
      beat(1, 1, 0, 0, col_rand());
      lat++;
    end
    check("stall_reached", out_valid, 1);
    rec_v = out_valid;
    rec_c = conv_value;
    repeat (3) begin
      beat(0, 1, 1, 1, col_rand());
      check("stall_valid", out_valid, rec_v);
      check("stall_conv", conv_value, rec_c);
    end
    repeat (4) beat(1, 1, 0, 0, col_rand());
    drain("drain_stall");

    // row restart after three columns
    set_filter(1); load_filter();
    beat(1, 1, 1, 0, col_rand());
    repeat (2) beat(1, 1, 0, 0, col_rand());
    beat(1, 1, 1, 0, col_rand());
    for (int i = 0; i < 3; i++) begin
      beat(1, 1, 0, 0, col_rand());
      check("restart_not_full", window_full, 0);
    end
    beat(1, 1, 0, 0, col_rand());
    check("restart_full", window_full, 1);
    drain("drain_restart");

    // filter load on the launching edge: old weights (25), then new (50)
    beat(1, 1, 1, 0, col_all(1));
    repeat (3) beat(1, 1, 0, 0, col_all(1));
    set_filter(2);
    beat(1, 1, 0, 1, col_all(1));
    beat(1, 1, 0, 0, col_all(1));
    drain("drain_fload");

    // reset with results in flight
    set_filter(1); load_filter();
    beat(1, 1, 1, 0, col_all(3));
    repeat (6) beat(1, 1, 0, 0, col_all(3));
    model_clear();
    rst = 1'b0; in_valid = 1'b0; row_start = 1'b0; filter_load = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_valid", out_valid, 0);
    check("midrst_full", window_full, 0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      idle();
      check("postrst_quiet", out_valid, 0);
    end

    // random mix of stalls, restarts and filter reloads
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) < 4) set_filter_rand();
      beat($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 8,
           $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 4, col_rand());
    end
    drain("drain_random");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/conv_kxk_pipe.md
Name: conv_kxk_pipe

Overview:
- Parametrised, pipelined KxK sliding-window convolution engine.
- Successor of the fixed 5x5 single-cycle MAC window. Adds generic kernel size K, a registered multiply stage and a registered adder tree, valid tracking, window-fill tracking, row restart and pipeline stall.
- Sits between the line-buffer/BRAM row readers and the pooling/activation stage of the LeNet-style datapath.
- Consumes one K-pixel column per accepted beat and emits one dot product per full window.

Parameters:
- BIT_WIDTH, 8: signed width of each pixel and weight.
- OUT_WIDTH, 32: signed width of the result. Must satisfy OUT_WIDTH >= 2*BIT_WIDTH + clog2(K*K); elaboration error otherwise.
- K, 5: kernel side (3..7); the window holds K*K taps.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset (sampled on the clk rising edge, low = reset).
- en  in  1  pipeline advance; when low, every register (window, filter, products, tree, valids, counter) holds.
- row_start  in  1  first column of a new image row; clears the fill count before this beat's column is counted.
- in_valid  in  1  column_in is valid this cycle.
- column_in  in  BIT_WIDTH*K  signed pixels; row r at bits [BIT_WIDTH*(r+1)-1 : BIT_WIDTH*r].
- filter_load  in  1  latch filter into the weight register.
- filter  in  BIT_WIDTH*K*K  weights; tap (r,c) at index K*r+c, with c=0 the oldest column.
- out_valid  out  1  conv_value holds a new result this cycle.
- conv_value  out  OUT_WIDTH  signed window dot product.
- window_full  out  1  at least K columns accepted since the last row_start/reset.

Behaviour:
- Accept rule: a beat is accepted when en=1 and in_valid=1. An accepted beat shifts every window row by one column; column_in enters column K-1 (newest) and column 0 (oldest) is discarded.
- Fill counter:
  - Saturates at K.
  - Reset value 0.
  - Accepted beat with row_start=1: counter set to 1.
  - Accepted beat otherwise: counter incremented (saturating).
  - row_start=1 with no accepted beat: counter set to 0.
- window_full = (count == K).
- Stage 0 (window): the accepted beat that makes count==K, or any accepted beat while count==K, launches a valid token v0. Non-accepted cycles with en=1 launch v0=0.
- Stage 1 (multiply): K*K registered signed products, 2*BIT_WIDTH bits each, sign-extended to OUT_WIDTH. Weights come from the weight register as it stands in the cycle the products are computed.
- Tree: TREE_DEPTH = clog2(K*K) registered levels of pairwise adds. An odd leftover operand passes through a register to the next level unchanged.
- Arithmetic is OUT_WIDTH two's complement, wrapping; no saturation.
- Latency LAT = TREE_DEPTH + 2 enabled edges from the accepting edge of the window-completing beat to out_valid=1. K=5 gives LAT=7; K=3 gives LAT=6.
- Throughput: one result per accepted beat once full.
- Valid bits travel in a shift register parallel to the data and advance only when en=1.
- Stall: while en=0, all registers hold, so out_valid and conv_value keep their values. A downstream consumer must gate on out_valid & en.
- Filter: on filter_load=1 with en=1, the weight register takes filter at that edge. A window launched in the same cycle uses the old weights; later windows use the new weights. Results already in the tree are unaffected.
- Reset: out_valid=0, conv_value=0, window_full=0, count=0, all valid bits 0, window and weight registers 0. Reset mid-operation discards all in-flight results, and no out_valid pulse follows it.
- Simultaneous events:
  - row_start + in_valid + full window: the counter goes to 1 and no token is launched.
  - Results in flight from the previous row still emerge.

Optional Feature:
- CONV_KXK_RELU_EN defined: the final tree register stores max(sum, 0); negative results become 0, and out_valid timing is unchanged.
- Undefined: the raw signed sum is output.

Decomposition:
- Package conv_pkg:
  - clog2 constant function.
  - Derived constants TREE_DEPTH(K) and LAT(K).
  - Tap index helper (K*r+c).
- Sub-module adder_tree_pipe (N operands, OUT_WIDTH, en, valid passthrough), holding the registered reduction levels.
- Window, counter and multipliers stay in the top level.

Test Plan:
- K=5, all weights 1, all pixels 1: stream 5 columns after row_start -> out_valid at edge 7 after the 5th accept, conv_value=25. Then one result per beat.
- K=5, weights 1, pixel = column index 0..6 on every row: 3 outputs = 5*(0+1+2+3+4)=50, then 75, then 100.
- Signed extremes, all pixels -128, all weights -128 (K=5): conv_value=25*16384=409600. With CONV_KXK_RELU_EN, weights +127 and pixels -128 -> conv_value=0.
- en held low for 3 cycles mid-stream: out_valid and conv_value frozen, no result lost or duplicated, and the sequence resumes exactly.
- row_start after 3 columns, then 5 more columns: no output until the 5th column of the new row, and window_full rises exactly then.
- filter_load to all-2 on the same edge as a window launch: that result uses the old weights (25), the next uses the new (50). Asserting rst low mid-stream: out_valid=0 the next cycle and no stale pulses follow.
